uart_rx: RTL

8N1 UART receiver clocked from the 50 MHz board clock. It is the stage directly downstream of the `uart` transmitter and consumes its `tx` line. It recovers bytes at 115200 baud and presents each one with a single-cycle valid strobe. Frames with a bad stop bit are flagged. The block is used in loopback against the transmitter and as the command-receive path of the bot.

---
 rtl/uart_rx.sv | 132 +++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a 2-flop input synchronizer and mid-bit sampling.
// Ports: clk_50M/rst (sync active-high), rx line in; rx_data, rx_valid, frame_err, busy out.
module uart_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk_50M,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    idx_q;
    logic [7:0]    sh_q;
    logic [7:0]    data_q;
    logic          valid_q;
    logic          ferr_q;
    logic          rx_s1_q;
    logic          rx_s_q;

    logic          cnt_half;
    logic          cnt_full;
    logic [CW-1:0] cnt_inc;

    assign cnt_half = (cnt_q == CW'(HALF_BIT));
    assign cnt_full = (cnt_q == CW'(CLKS_PER_BIT));
    assign cnt_inc  = cnt_q + CW'(1);

    always_ff @(posedge clk_50M) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            rx_s1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            rx_s1_q <= rx;
            rx_s_q  <= rx_s1_q;
            // Strobes default low so they can never last beyond one cycle.
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (!rx_s_q) begin
                        state_q <= START;
                        cnt_q   <= CW'(1);
                    end
                end
                START: begin
                    if (cnt_half) begin
                        // A line back high at mid start bit is a glitch.
                        if (!rx_s_q) begin
                            state_q <= DATA;
                            cnt_q   <= CW'(1);
                            idx_q   <= '0;
                        end else begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                DATA: begin
                    if (cnt_full) begin
                        sh_q  <= {rx_s_q, sh_q[7:1]};
                        cnt_q <= CW'(1);
                        if (idx_q == 3'd7) begin
                            state_q <= STOP;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                STOP: begin
                    if (cnt_full) begin
                        cnt_q <= '0;
                        if (rx_s_q) begin
                            data_q  <= sh_q;
                            valid_q <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= WAIT_HIGH;
                        end
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                WAIT_HIGH: begin
                    // Hold off start detection through a break condition.
                    cnt_q <= '0;
                    if (rx_s_q) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != IDLE);

endmodule
